ysyx_25030093_wb_arb: RTL

Write-back controller and arbiter for the single register-file write port. It accepts write-back requests from two producers:
- EXU, for ALU/CSR results.
- LSU, for load results.

It grants one request at a time using round-robin on conflict, then sequences a one-cycle register-file write plus a commit pulse. It sits between EXU/LSU and the regfile, replacing direct per-unit write-back muxing.

---
 rtl/ysyx_25030093_wb_pkg.sv | 23 ++
 rtl/ysyx_25030093_rr_arb2.sv | 33 +++
 rtl/ysyx_25030093_wb_arb.sv | 118 +++++++++++
 3 files changed

// File: rtl/ysyx_25030093_wb_pkg.sv
// ============================================================================
// Module      : ysyx_25030093_wb_pkg
// Description : Shared types and constants for the write-back arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ysyx_25030093_wb_pkg;

    localparam int c_XLEN = 32;
    localparam int c_RA_W = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } wb_state_e;

    localparam logic c_SRC_EXU = 1'b0;
    localparam logic c_SRC_LSU = 1'b1;

endpackage

`default_nettype wire

// File: rtl/ysyx_25030093_rr_arb2.sv
// ============================================================================
// Module      : ysyx_25030093_rr_arb2
// Description : Two-way round-robin arbiter with a one-hot grant; bit 0 is
//               requester 0 (EXU), bit 1 is requester 1 (LSU).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_25030093_rr_arb2
    import ysyx_25030093_wb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       en,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                // On conflict, favour whichever side was not granted last.
                2'b11:   gnt = (last == c_SRC_LSU) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/ysyx_25030093_wb_arb.sv
// ============================================================================
// Module      : ysyx_25030093_wb_arb
// Description : Register-file write-back arbiter for EXU and LSU; one write
//               and one commit pulse per accepted request. Define
//               YSYX_25030093_WB_PERF_EN to add the perf counter ports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_25030093_wb_arb
    import ysyx_25030093_wb_pkg::*;
#(
    parameter int XLEN = c_XLEN,
    parameter int RA_W = c_RA_W
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            exu_valid,
    output logic            exu_ready,
    input  logic            exu_wen,
    input  logic [RA_W-1:0] exu_rd,
    input  logic [XLEN-1:0] exu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic            lsu_wen,
    input  logic [RA_W-1:0] lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            rf_wen,
    output logic [RA_W-1:0] rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            commit_valid,
    output logic            commit_src,
    output logic            busy
`ifdef YSYX_25030093_WB_PERF_EN
    ,
    output logic [31:0]     perf_exu_cnt,
    output logic [31:0]     perf_lsu_cnt,
    output logic [31:0]     perf_conflict_cnt
`endif
);

    wb_state_e       r_state;
    logic            r_last_src;
    logic            r_src;
    logic            r_wen;
    logic [RA_W-1:0] r_rd;
    logic [XLEN-1:0] r_data;

    logic [1:0]      w_gnt;
    logic            w_exu_hs;
    logic            w_lsu_hs;
    logic            w_write;

    ysyx_25030093_rr_arb2 u_rr_arb2 (
        .req  ({lsu_valid, exu_valid}),
        .last (r_last_src),
        .en   ((r_state == IDLE) && !reset),
        .gnt  (w_gnt)
    );

    assign exu_ready = w_gnt[0];
    assign lsu_ready = w_gnt[1];
    assign w_exu_hs  = exu_valid && exu_ready;
    assign w_lsu_hs  = lsu_valid && lsu_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_last_src <= c_SRC_LSU;
            r_src      <= c_SRC_EXU;
            r_wen      <= 1'b0;
            r_rd       <= '0;
            r_data     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_exu_hs || w_lsu_hs) begin
                        r_state    <= WRITE;
                        r_last_src <= w_lsu_hs ? c_SRC_LSU : c_SRC_EXU;
                        r_src      <= w_lsu_hs ? c_SRC_LSU : c_SRC_EXU;
                        r_wen      <= w_lsu_hs ? lsu_wen  : exu_wen;
                        r_rd       <= w_lsu_hs ? lsu_rd   : exu_rd;
                        r_data     <= w_lsu_hs ? lsu_data : exu_data;
                    end
                end
                WRITE:   r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Reset landing on the WRITE cycle suppresses both the write and the commit.
    assign w_write      = (r_state == WRITE) && !reset;
    assign rf_wen       = w_write && r_wen && (r_rd != '0);
    assign rf_waddr     = w_write ? r_rd   : '0;
    assign rf_wdata     = w_write ? r_data : '0;
    assign commit_valid = w_write;
    assign commit_src   = w_write && r_src;
    assign busy         = (r_state != IDLE);

`ifdef YSYX_25030093_WB_PERF_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_exu_cnt      <= '0;
            perf_lsu_cnt      <= '0;
            perf_conflict_cnt <= '0;
        end else begin
            if (commit_valid && (r_src == c_SRC_EXU)) perf_exu_cnt <= perf_exu_cnt + 32'd1;
            if (commit_valid && (r_src == c_SRC_LSU)) perf_lsu_cnt <= perf_lsu_cnt + 32'd1;
            if ((r_state == IDLE) && exu_valid && lsu_valid)
                perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
        end
    end
`endif

endmodule

`default_nettype wire
